ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
// Host-to-device PS/2 transmitter; sends command bytes (0xED LED set, 0xFF reset, 0xF4 enable) to the keyboard.
// Drives the open-drain PS/2 clock and data lines through output-enable pins.
// Gates the keyboard receive path via tx_active so the scancode decoder never sees host frames.
// Sits beside the PS/2 receiver that feeds the SAM keyboard-matrix decoder.
// PARAMETERS
// CLK_HZ      24000000  system clock frequency, Hz
// INHIBIT_US  100       time clock is held low before request-to-send, us
// TIMEOUT_MS  15        max wait for the device to clock, per phase, ms
// PORTS
// clk         in   1  system clock
// rst         in   1  synchronous reset, active-high
// tx_data     in   8  command byte, sampled on the accepted tx_start
// tx_start    in   1  request to send; accepted only when tx_busy=0
// tx_busy     out  1  high from the accepted start until the done/error cycle inclusive
// tx_done     out  1  1-cycle pulse: device ACKed the frame
// tx_error    out  1  1-cycle pulse: timeout or missing ACK
// tx_active   out  1  high while in any non-IDLE state; receiver ignores the lines
// ps2clk_in   in   1  raw PS/2 clock line (asynchronous)
// ps2dat_in   in   1  raw PS/2 data line (asynchronous)
// ps2clk_oe   out  1  1 = pull clock line low
// ps2dat_oe   out  1  1 = pull data line low
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, lines released. Applies within one cycle from any state, mid-frame included.
// - Inputs: 2-FF synchroniser. Clock also passes an 8-sample glitch filter; a filtered falling edge = fclk_fall (1-cycle strobe).
// - Frame format: start 0, d0..d7 LSB first, odd parity, stop 1; the device then ACKs with data low.
// - IDLE: tx_start&&!tx_busy -> latch tx_data, compute parity=~^tx_data -> INHIBIT, tx_busy=1 on the next cycle.
// - INHIBIT: clk_oe=1 for INHIBIT_US*CLK_HZ/1e6 cycles (2400 at default) -> REQ.
// - REQ: dat_oe=1 (start bit) and clk_oe=0 in the same cycle. Load the timeout counter -> SHIFT.
// - SHIFT: 10-bit frame {stop,parity,data}. On each fclk_fall, present the next bit: dat_oe = ~bit.
//   The bit counter runs 0..9; after the 10th fclk_fall (stop bit presented, dat_oe=0) -> ACK.
// - ACK: on fclk_fall, sample data. If 0 -> WAITIDLE; if 1 -> ERR.
// - WAITIDLE: wait for filtered clock=1 and data=1 -> DONE.
// - DONE: tx_done=1 for 1 cycle -> IDLE. ERR: tx_error=1 and release both lines for 1 cycle -> IDLE.
// - Timeout: a single counter, TIMEOUT_MS*CLK_HZ/1000 cycles (360000 at default, 19 bits).
//   It is loaded on REQ entry and reloaded on every fclk_fall. Expiry in SHIFT, ACK or WAITIDLE -> ERR.
// - tx_start while busy is ignored, with no queueing. tx_start in the DONE/ERR cycle is also ignored.
// - Device clocking during INHIBIT has no effect; the host owns the line.
// - Parity is odd over the 8 data bits: 0xED -> parity 1, 0xFF -> parity 1, 0xF4 -> parity 0.
// STRUCTURE
// - ps2_defs.vh: state encodings, the PS2_CMD_* constants (ED/FF/F4/EE), and the cycle-count macros derived from the parameters.
// - Sub-module ps2_line_filter: synchroniser, 8-tap filter, and falling-edge strobe for clk. It is also reused by the receiver.
// - Top level: FSM, shift register, bit counter, inhibit/timeout counter.
// TESTING
// - The bench includes a PS/2 device model: clock period 80us, samples data on rising edges, drives ACK.
// - 0xED sent -> the model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1. After ACK low: one tx_done pulse, tx_error=0.
// - Clock hold: clk_oe high for exactly 2400 cycles before dat_oe rises; clk_oe=0 in the same cycle dat_oe=1.
// - Device never clocks after REQ -> tx_error pulse at 360000 cycles +-1 after REQ, lines released, back to IDLE.
// - Model omits ACK (data stays 1 on the 11th edge) -> tx_error pulse, no tx_done.
// - rst asserted after the 4th data bit -> next cycle clk_oe=dat_oe=0 and tx_busy=0. A new 0xFF is then sent cleanly.
// - Second tx_start (0xF4) during a busy 0xED -> ignored; one frame only. 1-cycle 50ns clock glitches -> no extra bits shifted.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, keyboard command
// bytes and the helpers that turn time parameters into clock-cycle counts.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StDone,
    StErr
  } tx_state_e;

  localparam logic [7:0] PS2_CMD_ED = 8'hED;
  localparam logic [7:0] PS2_CMD_FF = 8'hFF;
  localparam logic [7:0] PS2_CMD_F4 = 8'hF4;
  localparam logic [7:0] PS2_CMD_EE = 8'hEE;

  localparam int unsigned FILTER_TAPS = 8;

  // amount * clk_hz / per_second, widened so 24 MHz * 100 us cannot overflow
  function automatic int unsigned cycles_from(input int unsigned amount,
                                              input int unsigned clk_hz,
                                              input int unsigned per_second);
    longint unsigned prod;
    prod = longint'(amount) * longint'(clk_hz);
    return int'(prod / longint'(per_second));
  endfunction

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchroniser plus 8-sample glitch filter for a PS/2 line, with a one-cycle
// strobe on every filtered falling edge.
module ps2_host_tx_line_filter
  import ps2_host_tx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic [1:0]             r_sync;
  logic [FILTER_TAPS-1:0] r_taps;
  logic                   r_level;
  logic                   r_fall;
  logic                   w_level_next;

  // Level only moves once all taps agree; anything shorter is a glitch.
  always_comb begin
    w_level_next = r_level;
    if (&r_taps) begin
      w_level_next = 1'b1;
    end else if (~|r_taps) begin
      w_level_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '1;
      r_taps  <= '1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_line};
      r_taps  <= {r_taps[FILTER_TAPS-2:0], r_sync[1]};
      r_level <= w_level_next;
      r_fall  <= r_level & ~w_level_next;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, shifts
// out one command frame on device clock edges and checks the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_active,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int unsigned INHIBIT_CYC = cycles_from(INHIBIT_US, CLK_HZ, 1000000);
  localparam int unsigned TIMEOUT_CYC = cycles_from(TIMEOUT_MS, CLK_HZ, 1000);
  localparam int unsigned CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  // Expiry decided one cycle early so the error pulse lands TIMEOUT_CYC after the reload.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 2);

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_dat_oe;
  logic [1:0]       r_dat_sync;
  logic             w_clk_level;
  logic             w_clk_fall;
  logic             w_dev_phase;
  logic             w_tmo_expired;

  ps2_host_tx_line_filter u_clk_filter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_line  (ps2clk_in),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat_sync <= '1;
    end else begin
      r_dat_sync <= {r_dat_sync[0], ps2dat_in};
    end
  end

  assign w_dev_phase   = (r_state == StShift) || (r_state == StAck) || (r_state == StWaitIdle);
  assign w_tmo_expired = w_dev_phase && (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (tx_start) w_state_next = StInhibit;
      StInhibit:  if (r_cnt == INHIBIT_LAST) w_state_next = StReq;
      StReq:      w_state_next = StShift;
      StShift: begin
        if (w_clk_fall && (r_bit_cnt == 4'd9)) begin
          w_state_next = StAck;
        end else if (w_tmo_expired) begin
          w_state_next = StErr;
        end
      end
      StAck: begin
        if (w_clk_fall) begin
          w_state_next = r_dat_sync[1] ? StErr : StWaitIdle;
        end else if (w_tmo_expired) begin
          w_state_next = StErr;
        end
      end
      StWaitIdle: begin
        if (w_clk_level && r_dat_sync[1]) begin
          w_state_next = StDone;
        end else if (w_tmo_expired) begin
          w_state_next = StErr;
        end
      end
      StDone:     w_state_next = StIdle;
      StErr:      w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // One counter serves both the inhibit hold and the per-edge device timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == StIdle) || (r_state == StReq) || (w_dev_phase && w_clk_fall)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_dat_oe  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_dat_oe <= 1'b0;
          if (tx_start) r_shift <= {1'b1, odd_parity(tx_data), tx_data};
        end
        StReq: begin
          r_bit_cnt <= '0;
          r_dat_oe  <= 1'b1;
        end
        StShift: begin
          if (w_clk_fall) begin
            r_dat_oe  <= ~r_shift[0];
            r_shift   <= {1'b0, r_shift[9:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ps2clk_oe = 1'b0;
    ps2dat_oe = 1'b0;
    tx_done   = 1'b0;
    tx_error  = 1'b0;
    tx_active = (r_state != StIdle);
    tx_busy   = (r_state != StIdle);
    unique case (r_state)
      StInhibit:                  ps2clk_oe = 1'b1;
      StReq:                      ps2dat_oe = 1'b1;
      StShift, StAck, StWaitIdle: ps2dat_oe = r_dat_oe;
      StDone:                     tx_done   = 1'b1;
      StErr:                      tx_error  = 1'b1;
      default: ;
    endcase
  end

endmodule
